// File: rtl/payment_pkg.sv
// Shared types and constants for the payment controller: FSM state encoding,
// coin_sel encodings and the face value of each coin denomination.
package payment_pkg;

  // Order lifecycle states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3,
    ST_REFUND   = 3'd4
  } state_e;

  // coin_sel encodings.
  localparam logic [1:0] COIN_SEL_1  = 2'b00;
  localparam logic [1:0] COIN_SEL_5  = 2'b01;
  localparam logic [1:0] COIN_SEL_10 = 2'b10;
  localparam logic [1:0] COIN_SEL_20 = 2'b11;

  // Face value of each denomination.
  localparam int unsigned COIN_VAL_1  = 1;
  localparam int unsigned COIN_VAL_5  = 5;
  localparam int unsigned COIN_VAL_10 = 10;
  localparam int unsigned COIN_VAL_20 = 20;

endpackage

// File: rtl/payment_ctrl_coin_decoder.sv
// Combinational coin decoder: maps a 2-bit coin_sel to its DW-bit money value.
module coin_decoder
  import payment_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [1:0]    coin_sel_i,
  output logic [DW-1:0] value_o
);

  // Denomination lookup.
  always_comb begin
    // NOTE: the output gets a default before the case so no latch is inferred.
    value_o = '0;
    case (coin_sel_i)
      COIN_SEL_1:  value_o = DW'(COIN_VAL_1);
      COIN_SEL_5:  value_o = DW'(COIN_VAL_5);
      COIN_SEL_10: value_o = DW'(COIN_VAL_10);
      COIN_SEL_20: value_o = DW'(COIN_VAL_20);
      default:     value_o = '0;
    endcase
  end

endmodule

// File: rtl/payment_ctrl.sv
// Payment controller: opens an order on start, collects coins until the price
// is covered, issues one ticket_pulse per ticket, then closes the order with
// change (or refunds everything paid when the customer cancels).
module payment_ctrl
  import payment_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] total,
  input  logic [DW-1:0] ticket,
  input  logic          start,
  input  logic          coin_valid,
  input  logic [1:0]    coin_sel,
  input  logic          cancel,
  output logic          busy,
  output logic [DW-1:0] paid,
  output logic          coin_reject,
  output logic          ticket_pulse,
  output logic [DW-1:0] change,
  output logic          done,
  output logic          refund
);

  localparam logic [DW-1:0] ONE = DW'(1);

  state_e        state_q, state_d;
  logic [DW-1:0] total_q, total_d;
  logic [DW-1:0] ticket_q, ticket_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] paid_q, paid_d;
  logic [DW-1:0] change_q, change_d;
  logic          coin_reject_q, coin_reject_d;
  logic          done_q, done_d;
  logic          refund_q, refund_d;

  logic [DW-1:0] coin_value;
  logic [DW:0]   coin_sum;
  logic          coin_fits;

  coin_decoder #(.DW(DW)) u_coin_decoder (
    .coin_sel_i (coin_sel),
    .value_o    (coin_value)
  );

  // The extra carry bit tells whether paid + coin still fits in DW bits.
  assign coin_sum  = {1'b0, paid_q} + {1'b0, coin_value};
  assign coin_fits = ~coin_sum[DW];

  // Next-state and next-output logic for the order FSM.
  always_comb begin
    state_d       = state_q;
    total_d       = total_q;
    ticket_d      = ticket_q;
    cnt_d         = cnt_q;
    paid_d        = paid_q;
    change_d      = change_q;
    // Any presented coin bounces unless COLLECT explicitly accepts it below.
    coin_reject_d = coin_valid;
    done_d        = 1'b0;
    refund_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // paid stays visible during the done cycle and clears one edge later.
        if (done_q) paid_d = '0;
        if (start && (total != '0) && (ticket != '0)) begin
          total_d  = total;
          ticket_d = ticket;
          paid_d   = '0;
          change_d = '0;
          cnt_d    = '0;
          state_d  = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (cancel) begin
          state_d = ST_REFUND;
        end else begin
          if (coin_valid && coin_fits) begin
            paid_d        = coin_sum[DW-1:0];
            coin_reject_d = 1'b0;
          end
          // Threshold uses the registered sum; a coin this cycle still counts.
          if (paid_q >= total_q) state_d = ST_DISPENSE;
        end
      end

      ST_DISPENSE: begin
        if (cnt_q == ticket_q - ONE) begin
          cnt_d   = '0;
          state_d = ST_CHANGE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      ST_CHANGE: begin
        change_d = paid_q - total_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end

      ST_REFUND: begin
        change_d = paid_q;
        done_d   = 1'b1;
        refund_d = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any order silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      total_q       <= '0;
      ticket_q      <= '0;
      cnt_q         <= '0;
      paid_q        <= '0;
      change_q      <= '0;
      coin_reject_q <= 1'b0;
      done_q        <= 1'b0;
      refund_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      total_q       <= total_d;
      ticket_q      <= ticket_d;
      cnt_q         <= cnt_d;
      paid_q        <= paid_d;
      change_q      <= change_d;
      coin_reject_q <= coin_reject_d;
      done_q        <= done_d;
      refund_q      <= refund_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign ticket_pulse = (state_q == ST_DISPENSE);
  assign paid         = paid_q;
  assign change       = change_q;
  assign coin_reject  = coin_reject_q;
  assign done         = done_q;
  assign refund       = refund_q;

endmodule

// File: tb/tb_payment_ctrl.sv
// Self-checking bench for payment_ctrl: directed scenarios followed by random
// orders, all compared against a transaction-level money model.
module tb_payment_ctrl;

  localparam int DW      = 8;
  localparam int MAX_SUM = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] total, ticket;
  logic          start, coin_valid, cancel;
  logic [1:0]    coin_sel;
  logic          busy, coin_reject, ticket_pulse, done, refund;
  logic [DW-1:0] paid, change;

  payment_ctrl #(.DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .total        (total),
    .ticket       (ticket),
    .start        (start),
    .coin_valid   (coin_valid),
    .coin_sel     (coin_sel),
    .cancel       (cancel),
    .busy         (busy),
    .paid         (paid),
    .coin_reject  (coin_reject),
    .ticket_pulse (ticket_pulse),
    .change       (change),
    .done         (done),
    .refund       (refund)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: money accepted so far in the open order.
  int          exp_paid = 0;
  int unsigned denom [4] = '{1, 5, 10, 20};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic open_order(input int t, input int k);
    total  = DW'(t);
    ticket = DW'(k);
    start  = 1'b1;
    step();
    start  = 1'b0;
    // Later changes on total/ticket must not affect the open order.
    total  = DW'($urandom);
    ticket = DW'($urandom);
    exp_paid = 0;
    check("open.busy", 32'(busy), 1);
    check("open.paid", 32'(paid), 0);
    check("open.change", 32'(change), 0);
  endtask

  task automatic insert_coin(input int sel);
    int   val;
    logic exp_rej;
    val = int'(denom[sel]);
    if (exp_paid + val <= MAX_SUM) begin
      exp_paid = exp_paid + val;
      exp_rej  = 1'b0;
    end else begin
      exp_rej  = 1'b1;
    end
    coin_valid = 1'b1;
    coin_sel   = 2'(sel);
    step();
    coin_valid = 1'b0;
    check("coin.paid", 32'(paid), 32'(exp_paid));
    check("coin.reject", 32'(coin_reject), 32'(exp_rej));
    check("coin.busy", 32'(busy), 1);
  endtask

  // Called right after the step on which paid reached the price. Sample j
  // (1-based) after that edge: j<=k ticket pulses, j=k+1 closing, j=k+2 done.
  // A coin and a cancel are thrown at the first dispense cycle.
  task automatic finish_sale(input int t, input int k);
    for (int j = 1; j <= k + 2; j++) begin
      step();
      if (j == 2) begin
        coin_valid = 1'b0;
        cancel     = 1'b0;
        check("sale.disp_reject", 32'(coin_reject), 1);
      end
      check("sale.pulse", 32'(ticket_pulse), 32'(j <= k));
      check("sale.done", 32'(done), 32'(j == k + 2));
      if (j == 1) begin
        coin_valid = 1'b1;
        coin_sel   = 2'b11;
        cancel     = 1'b1;
      end
    end
    check("sale.change", 32'(change), 32'(exp_paid - t));
    check("sale.refund", 32'(refund), 0);
    check("sale.busy", 32'(busy), 0);
    check("sale.paid_hold", 32'(paid), 32'(exp_paid));
    step();
    check("sale.done_off", 32'(done), 0);
    check("sale.paid_clr", 32'(paid), 0);
    check("sale.change_hold", 32'(change), 32'(exp_paid - t));
    exp_paid = 0;
  endtask

  task automatic cancel_order(input logic with_coin, input int sel);
    cancel     = 1'b1;
    coin_valid = with_coin;
    coin_sel   = 2'(sel);
    step();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    check("cancel.reject", 32'(coin_reject), 32'(with_coin));
    check("cancel.paid", 32'(paid), 32'(exp_paid));
    check("cancel.busy", 32'(busy), 1);
    check("cancel.done_early", 32'(done), 0);
    step();
    check("cancel.done", 32'(done), 1);
    check("cancel.refund", 32'(refund), 1);
    check("cancel.change", 32'(change), 32'(exp_paid));
    check("cancel.pulse", 32'(ticket_pulse), 0);
    check("cancel.busy_off", 32'(busy), 0);
    step();
    check("cancel.done_off", 32'(done), 0);
    check("cancel.refund_off", 32'(refund), 0);
    check("cancel.paid_clr", 32'(paid), 0);
    exp_paid = 0;
  endtask

  initial begin
    int t, k, cancel_at, n;
    logic do_cancel, cancelled;

    rst_n = 1'b0; start = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
    coin_sel = 2'b00; total = '0; ticket = '0;

    // Reset state.
    #3;
    check("rst.busy", 32'(busy), 0);
    check("rst.paid", 32'(paid), 0);
    check("rst.change", 32'(change), 0);
    check("rst.done", 32'(done), 0);
    check("rst.pulse", 32'(ticket_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Coin while idle bounces back for one cycle.
    coin_valid = 1'b1; coin_sel = 2'b01;
    step();
    coin_valid = 1'b0;
    check("idle.reject", 32'(coin_reject), 1);
    check("idle.paid", 32'(paid), 0);
    step();
    check("idle.reject_off", 32'(coin_reject), 0);

    // Start with a zero price or zero tickets is ignored.
    total = 8'd0; ticket = 8'd3; start = 1'b1;
    step();
    check("zero_total.busy", 32'(busy), 0);
    total = 8'd5; ticket = 8'd0;
    step();
    start = 1'b0;
    check("zero_ticket.busy", 32'(busy), 0);

    // Price 6, two tickets, coins 5 and 1: exact payment.
    open_order(6, 2);
    insert_coin(1);
    insert_coin(0);
    finish_sale(6, 2);

    // Price 4, one ticket, coin 20: change 16.
    open_order(4, 1);
    insert_coin(3);
    finish_sale(4, 1);

    // Price 30, three tickets, 10 + 5 then cancel: refund 15.
    open_order(30, 3);
    insert_coin(2);
    insert_coin(1);
    cancel_order(1'b0, 0);

    // Price 255: fill to 250, then a 20 overflows and is rejected.
    open_order(255, 1);
    for (int i = 0; i < 12; i++) insert_coin(3);
    insert_coin(2);
    insert_coin(3);
    check("ovf.paid", 32'(paid), 250);
    step();
    check("ovf.reject_off", 32'(coin_reject), 0);
    // A new start mid-order is ignored.
    total = 8'd1; ticket = 8'd7; start = 1'b1;
    step();
    start = 1'b0;
    check("ovf.busy", 32'(busy), 1);
    check("ovf.paid_hold", 32'(paid), 250);
    insert_coin(1);
    finish_sale(255, 1);

    // Cancel together with a coin: coin rejected, refund of prior money.
    open_order(50, 2);
    insert_coin(1);
    cancel_order(1'b1, 1);

    // Reset in the middle of dispensing.
    open_order(3, 3);
    insert_coin(1);
    step();
    check("rstmid.pulse_on", 32'(ticket_pulse), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid.busy", 32'(busy), 0);
    check("rstmid.paid", 32'(paid), 0);
    check("rstmid.pulse", 32'(ticket_pulse), 0);
    check("rstmid.change", 32'(change), 0);
    check("rstmid.done", 32'(done), 0);
    check("rstmid.refund", 32'(refund), 0);
    step();
    rst_n = 1'b1;
    exp_paid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstpost.done", 32'(done), 0);
      check("rstpost.busy", 32'(busy), 0);
    end
    total = 8'd0; ticket = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    check("rstpost.zero_start", 32'(busy), 0);

    // Random orders against the money model.
    for (int r = 0; r < 40; r++) begin
      t         = int'($urandom_range(1, MAX_SUM));
      k         = int'($urandom_range(1, 4));
      do_cancel = ($urandom_range(0, 3) == 0);
      cancel_at = int'($urandom_range(0, 5));
      cancelled = 1'b0;
      n         = 0;
      open_order(t, k);
      while (exp_paid < t && !cancelled) begin
        if ((do_cancel && n == cancel_at) || n >= 400) begin
          cancel_order(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
          cancelled = 1'b1;
        end else begin
          insert_coin(int'($urandom_range(0, 3)));
          n++;
        end
      end
      if (!cancelled) finish_sale(t, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
